// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
package ram_arb_pkg;

  // Requester identities; also used as the round-robin pointer value.
  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_AUX = 1'b1
  } port_e;

  // Arbitration policy selector values for PRIO_MODE.
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle of the RAM port arbiter.
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds them
// stable until gntN is seen; gntN is a one-cycle pulse meaning the access was
// put on the RAM port in that cycle. reqN still high during gntN is a new
// request. rvalidN marks the cycle in which rdata belongs to port N.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way picker: round-robin against the last granted port,
// or fixed priority to port 0.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  port_e      last_grant_i,
  input  logic       prio_fixed_i,
  output logic [1:0] grant_o
);

  // Pick at most one winner; on contention favour the port not served last.
  always_comb begin
    grant_o = 2'b00;
    if (req0_i && req1_i) begin
      if (prio_fixed_i || (last_grant_i == PORT_AUX)) grant_o = 2'b01;
      else                                            grant_o = 2'b10;
    end else if (req0_i) begin
      grant_o = 2'b01;
    end else if (req1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port data RAM between the CPU datapath (port 0) and the
// loader/debug port (port 1). The winner is registered onto the RAM port,
// a grant pulse follows one cycle after the request and read data two cycles.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int PRIO_MODE  = PRIO_RR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_port_arbiter_if.slave     bus,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  input  logic [DATA_WIDTH-1:0] ram_r_data
);

  logic [1:0]            grant;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  port_e                 last_q, last_d;

  rr_arb2 u_pick (
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .last_grant_i (last_q),
    .prio_fixed_i (PRIO_MODE == PRIO_FIXED),
    .grant_o      (grant)
  );

  // Next-state: load the winner onto the RAM port; idle keeps addr/data.
  // A read issued on the RAM port this cycle becomes rvalid next cycle.
  always_comb begin
    gnt_d    = grant;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    last_d   = last_q;
    rvalid_d = gnt_q & {2{~wr_en_q}};
    if (grant[0]) begin
      wr_en_d = bus.we0;
      addr_d  = bus.addr0;
      wdata_d = bus.wdata0;
      last_d  = PORT_CPU;
    end else if (grant[1]) begin
      wr_en_d = bus.we1;
      addr_d  = bus.addr1;
      wdata_d = bus.wdata1;
      last_d  = PORT_AUX;
    end
  end

  // State registers; reset drops in-flight reads and points RR at port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= PORT_AUX;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      last_q   <= last_d;
    end
  end

  assign bus.gnt0    = gnt_q[0];
  assign bus.gnt1    = gnt_q[1];
  assign bus.rvalid0 = rvalid_q[0];
  assign bus.rvalid1 = rvalid_q[1];
  assign bus.rdata   = ram_r_data;
  assign ram_wr_en   = wr_en_q;
  assign ram_addr    = addr_q;
  assign ram_w_data  = wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a round-robin instance backed by a
// behavioural RAM with registered read address, and a fixed-priority instance.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int DW = 4;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fbus ();

  logic          ram_wr_en, f_wr_en;
  logic [AW-1:0] ram_addr, f_addr;
  logic [DW-1:0] ram_w_data, f_w_data;
  logic [DW-1:0] ram_r_data;
  logic [DW-1:0] f_r_data;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIO_MODE(PRIO_RR)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ram_wr_en  (ram_wr_en),
    .ram_addr   (ram_addr),
    .ram_w_data (ram_w_data),
    .ram_r_data (ram_r_data)
  );

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIO_MODE(PRIO_FIXED)) u_fix (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (fbus),
    .ram_wr_en  (f_wr_en),
    .ram_addr   (f_addr),
    .ram_w_data (f_w_data),
    .ram_r_data (f_r_data)
  );

  assign f_r_data = '0;

  // Behavioural single-port RAM: write commits at the clock edge, read address
  // registered at the same edge, so read data follows the address by a cycle.
  logic [DW-1:0] mem [0:255];
  logic [AW-1:0] raddr_q = '0;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_w_data;
    raddr_q <= ram_addr;
  end
  assign ram_r_data = mem[raddr_q];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // One uncontended access on port p; req dropped in the grant cycle.
  task automatic single_access(input string tag, input int p, input logic we,
                               input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [DW-1:0] exp_rd);
    drive(p, 1'b1, we, a, d);
    check({tag, "_nogntC0"}, {31'd0, (p == 0) ? bus.gnt0 : bus.gnt1}, 32'd0);
    step();
    check({tag, "_gnt"},   {30'd0, bus.gnt1, bus.gnt0}, (p == 0) ? 32'd1 : 32'd2);
    check({tag, "_wr_en"}, {31'd0, ram_wr_en}, {31'd0, we});
    check({tag, "_addr"},  {24'd0, ram_addr}, {24'd0, a});
    if (we) check({tag, "_wdata"}, {28'd0, ram_w_data}, {28'd0, d});
    drive(p, 1'b0, we, a, d);
    step();
    check({tag, "_gnt_off"}, {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    check({tag, "_rvalid"},  {30'd0, bus.rvalid1, bus.rvalid0},
          we ? 32'd0 : ((p == 0) ? 32'd1 : 32'd2));
    check({tag, "_idle_wr"}, {31'd0, ram_wr_en}, 32'd0);
    check({tag, "_addr_hold"}, {24'd0, ram_addr}, {24'd0, a});
    if (!we) check({tag, "_rdata"}, {28'd0, bus.rdata}, {28'd0, exp_rd});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    check({tag, "_rvalid"}, {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    check({tag, "_wr_en"},  {31'd0, ram_wr_en}, 32'd0);
    check({tag, "_addr"},   {24'd0, ram_addr}, 32'd0);
    check({tag, "_wdata"},  {28'd0, ram_w_data}, 32'd0);
  endtask

  // Contention: winners per cycle after a port-0 grant, hand-derived.
  int            exp_win [1:6];
  logic [DW-1:0] exp_dat [0:1];

  // ---------------- main sequence ----------------
  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    fbus.req0 = 1'b0; fbus.we0 = 1'b0; fbus.addr0 = '0; fbus.wdata0 = '0;
    fbus.req1 = 1'b0; fbus.we1 = 1'b0; fbus.addr1 = '0; fbus.wdata1 = '0;

    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    check("reset_fix_gnt", {30'd0, fbus.gnt1, fbus.gnt0}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single write / read-back, plus preload for contention
    single_access("wr12",  0, 1'b1, 8'h12, 4'hA, 4'h0);
    single_access("rd12",  0, 1'b0, 8'h12, 4'h0, 4'hA);
    single_access("wr01",  0, 1'b1, 8'h01, 4'h3, 4'h0);
    single_access("wr02",  1, 1'b1, 8'h02, 4'h7, 4'h0);
    single_access("rd02",  1, 1'b0, 8'h02, 4'h0, 4'h7);
    single_access("rd01",  0, 1'b0, 8'h01, 4'h0, 4'h3);

    // Round-robin contention: last grant was port 0, so port 1 leads.
    exp_win[1] = 1; exp_win[2] = 0; exp_win[3] = 1;
    exp_win[4] = 0; exp_win[5] = 1; exp_win[6] = 0;
    exp_dat[0] = 4'h3; exp_dat[1] = 4'h7;
    drive(0, 1'b1, 1'b0, 8'h01, '0);
    drive(1, 1'b1, 1'b0, 8'h02, '0);
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("rr_gnt%0d", i), {30'd0, bus.gnt1, bus.gnt0},
            (exp_win[i] == 0) ? 32'd1 : 32'd2);
      if (i >= 2) begin
        check($sformatf("rr_rv%0d", i), {30'd0, bus.rvalid1, bus.rvalid0},
              (exp_win[i-1] == 0) ? 32'd1 : 32'd2);
        check($sformatf("rr_rd%0d", i), {28'd0, bus.rdata}, {28'd0, exp_dat[exp_win[i-1]]});
      end
    end
    drive(0, 1'b0, 1'b0, 8'h01, '0);
    drive(1, 1'b0, 1'b0, 8'h02, '0);
    step();
    check("rr_rv_last", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd1);
    check("rr_rd_last", {28'd0, bus.rdata}, 32'h3);
    check("rr_gnt_end", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);

    // Read-after-write on consecutive grants: port 1 writes, port 0 reads.
    drive(1, 1'b1, 1'b1, 8'h40, 4'h5);
    drive(0, 1'b1, 1'b0, 8'h40, '0);
    step();
    check("raw_gnt_w",  {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
    check("raw_wr_en",  {31'd0, ram_wr_en}, 32'd1);
    check("raw_waddr",  {24'd0, ram_addr}, 32'h40);
    drive(1, 1'b0, 1'b1, 8'h40, 4'h5);
    step();
    check("raw_gnt_r",  {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
    check("raw_rd_en",  {31'd0, ram_wr_en}, 32'd0);
    check("raw_no_rv1", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    drive(0, 1'b0, 1'b0, 8'h40, '0);
    step();
    check("raw_rv0",    {30'd0, bus.rvalid1, bus.rvalid0}, 32'd1);
    check("raw_rdata",  {28'd0, bus.rdata}, 32'h5);

    // Fixed priority: port 0 wins every cycle, port 1 only once port 0 drops.
    fbus.req0 = 1'b1; fbus.req1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("fix_gnt%0d", i), {30'd0, fbus.gnt1, fbus.gnt0}, 32'd1);
    end
    fbus.req0 = 1'b0;
    step();
    check("fix_gnt1_after", {30'd0, fbus.gnt1, fbus.gnt0}, 32'd2);
    fbus.req1 = 1'b0;
    step();
    check("fix_idle", {30'd0, fbus.gnt1, fbus.gnt0}, 32'd0);

    // Reset during the grant cycle of a read.
    drive(0, 1'b1, 1'b0, 8'h12, '0);
    step();
    check("rst_gnt_before", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
    drive(0, 1'b0, 1'b0, 8'h12, '0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_in");
    step();
    check("rst_held_rv", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
    #2 rst_n = 1'b1;
    step();
    check_all_zero("rst_after");
    drive(0, 1'b1, 1'b0, 8'h01, '0);
    drive(1, 1'b1, 1'b0, 8'h02, '0);
    step();
    check("rst_first_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
    drive(0, 1'b0, 1'b0, 8'h01, '0);
    step();
    check("rst_second_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
    check("rst_rv0",        {30'd0, bus.rvalid1, bus.rvalid0}, 32'd1);
    check("rst_rd0",        {28'd0, bus.rdata}, 32'h3);
    drive(1, 1'b0, 1'b0, 8'h02, '0);
    step();
    check("rst_rv1",        {30'd0, bus.rvalid1, bus.rvalid0}, 32'd2);
    check("rst_rd1",        {28'd0, bus.rdata}, 32'h7);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
